// File: rtl/nn_pkg.sv
// Shared definitions for the fixed-point layer engines.
// Contents:
//   FRAC_BITS            fractional bits of the Q16.16 format
//   L4_IN_DIM/L4_OUT_DIM layer-4 geometry (inputs per neuron, neurons)
//   L4_W_BASE            weight-ROM address of layer-4 row 0
//   ACC_W                accumulator width (64-bit products plus growth headroom)
//   FX_SAT_MAX/MIN       32-bit signed saturation limits
//   dense_state_e        dense-engine FSM state encoding
package nn_pkg;

  localparam int FRAC_BITS  = 16;
  localparam int L4_IN_DIM  = 32;
  localparam int L4_OUT_DIM = 10;
  localparam int L4_W_BASE  = 0;
  localparam int ACC_W      = 72;

  localparam logic signed [31:0] FX_SAT_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] FX_SAT_MIN = 32'sh8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } dense_state_e;

endpackage

// File: rtl/layer4_dense_engine_if.sv
// Bus bundle between the layer-4 dense engine and its surroundings.
// Signals:
//   start/busy/done/argmax      run control and predicted class
//   weight_addr/weight_data     weight ROM port (combinational read)
//   act_addr/act_data           activation buffer port (combinational read)
//   out_we/out_addr/out_data    result buffer write port
// Modports:
//   master  the engine side
//   slave   the environment side (ROM, buffers, controller)
interface layer4_dense_engine_if;

  logic               start;
  logic               busy;
  logic               done;
  logic [3:0]         argmax;
  logic [15:0]        weight_addr;
  logic signed [31:0] weight_data;
  logic [4:0]         act_addr;
  logic signed [31:0] act_data;
  logic               out_we;
  logic [3:0]         out_addr;
  logic signed [31:0] out_data;

  modport master (
    input  start, weight_data, act_data,
    output busy, done, argmax, weight_addr, act_addr, out_we, out_addr, out_data
  );

  modport slave (
    output start, weight_data, act_data,
    input  busy, done, argmax, weight_addr, act_addr, out_we, out_addr, out_data
  );

endinterface

// File: rtl/fx_requant.sv
// Combinational requantiser shared by the layer engines.
// Takes a wide signed accumulator, drops FRAC fractional bits with an
// arithmetic shift, saturates to the 32-bit signed range and optionally
// clamps negatives to zero.
// Ports:
//   acc_i     signed accumulator, ACC_BITS wide
//   result_o  signed 32-bit Q16.16 result
module fx_requant
  import nn_pkg::*;
#(
  parameter int ACC_BITS = ACC_W,
  parameter int FRAC     = nn_pkg::FRAC_BITS,
  parameter bit RELU_EN  = 1'b0
) (
  input  logic signed [ACC_BITS-1:0] acc_i,
  output logic signed [31:0]         result_o
);

  // Limits widened with sign extension so the comparisons stay signed.
  localparam logic signed [ACC_BITS-1:0] SAT_HI = ACC_BITS'(FX_SAT_MAX);
  localparam logic signed [ACC_BITS-1:0] SAT_LO = ACC_BITS'(FX_SAT_MIN);

  logic signed [ACC_BITS-1:0] shifted;

  assign shifted = acc_i >>> FRAC;

  always_comb begin
    result_o = shifted[31:0];
    if (shifted > SAT_HI) begin
      result_o = FX_SAT_MAX;
    end else if (shifted < SAT_LO) begin
      result_o = FX_SAT_MIN;
    end
    if (RELU_EN && result_o[31]) begin
      result_o = '0;
    end
  end

endmodule

// File: rtl/layer4_dense_engine.sv
// Layer-4 fully-connected engine: OUT_DIM neurons x IN_DIM inputs, Q16.16.
// Streams one weight/activation pair per cycle through a 72-bit MAC, writes
// each requantised result to the result buffer and tracks the argmax class.
// Ports:
//   clk     rising-edge clock
//   resetn  synchronous active-low reset
//   bus     master side of layer4_dense_engine_if (control, ROM, buffers)
module layer4_dense_engine
  import nn_pkg::*;
#(
  parameter int IN_DIM    = L4_IN_DIM,
  parameter int OUT_DIM   = L4_OUT_DIM,
  parameter int FRAC_BITS = nn_pkg::FRAC_BITS,
  parameter int W_BASE    = L4_W_BASE,
  parameter int RELU      = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  layer4_dense_engine_if.master bus
);

  localparam logic [4:0] LAST_I = 5'(IN_DIM - 1);
  localparam logic [3:0] LAST_O = 4'(OUT_DIM - 1);

  dense_state_e            state_q, state_d;
  logic [4:0]              i_q, i_d;
  logic [3:0]              o_q, o_d;
  logic [15:0]             waddr_q, waddr_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic signed [63:0]      w_ext, a_ext, prod;
  logic signed [31:0]      result;
  logic signed [31:0]      max_q, max_d;
  logic signed [31:0]      out_data_q, out_data_d;
  logic [3:0]              argmax_q, argmax_d;
  logic [3:0]              out_addr_q, out_addr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    out_we_q, out_we_d;

  // Full-precision product and running sum; nothing is truncated before
  // the requantiser.
  always_comb begin
    w_ext   = 64'(bus.weight_data);
    a_ext   = 64'(bus.act_data);
    prod    = w_ext * a_ext;
    acc_sum = acc_q + ACC_W'(prod);
  end

  // The requantiser sees the sum including the current product, so the
  // result is ready on the last MAC cycle and registered into WRITE.
  fx_requant #(
    .ACC_BITS (ACC_W),
    .FRAC     (FRAC_BITS),
    .RELU_EN  (RELU != 0)
  ) u_requant (
    .acc_i    (acc_sum),
    .result_o (result)
  );

  // Next-state logic. The write strobe, address and data are registered on
  // the edge that enters WRITE, so they are visible exactly during WRITE.
  // The weight address is a running counter: row-major layout means the
  // address after the last input of row o is the first of row o+1.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    o_d        = o_q;
    waddr_d    = waddr_q;
    acc_d      = acc_q;
    max_d      = max_q;
    argmax_d   = argmax_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    out_we_d   = 1'b0;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_MAC;
          i_d      = '0;
          o_d      = '0;
          waddr_d  = 16'(W_BASE);
          acc_d    = '0;
          max_d    = FX_SAT_MIN;
          argmax_d = '0;
          busy_d   = 1'b1;
        end
      end
      ST_MAC: begin
        acc_d   = acc_sum;
        waddr_d = waddr_q + 16'd1;
        if (i_q == LAST_I) begin
          i_d        = '0;
          state_d    = ST_WRITE;
          out_we_d   = 1'b1;
          out_addr_d = o_q;
          out_data_d = result;
          // Strict compare: on a tie the earlier (lower) index wins.
          if (result > max_q) begin
            max_d    = result;
            argmax_d = o_q;
          end
        end else begin
          i_d = i_q + 5'd1;
        end
      end
      ST_WRITE: begin
        acc_d = '0;
        i_d   = '0;
        if (o_q == LAST_O) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          o_d     = o_q + 4'd1;
          state_d = ST_MAC;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      i_q        <= '0;
      o_q        <= '0;
      waddr_q    <= '0;
      acc_q      <= '0;
      max_q      <= '0;
      argmax_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      out_we_q   <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      o_q        <= o_d;
      waddr_q    <= waddr_d;
      acc_q      <= acc_d;
      max_q      <= max_d;
      argmax_q   <= argmax_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      out_we_q   <= out_we_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.argmax      = argmax_q;
  assign bus.weight_addr = waddr_q;
  assign bus.act_addr    = i_q;
  assign bus.out_we      = out_we_q;
  assign bus.out_addr    = out_addr_q;
  assign bus.out_data    = out_data_q;

endmodule

// File: tb/tb_layer4_dense_engine.sv
// Testbench for layer4_dense_engine. Two instances (RELU=0 and RELU=1) run in
// lockstep from one weight ROM and one activation buffer model; each has a
// queue of expected writes that is checked whenever its out_we is high.
module tb_layer4_dense_engine;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  layer4_dense_engine_if bus0 ();
  layer4_dense_engine_if bus1 ();

  layer4_dense_engine #(.RELU(0)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus0)
  );

  layer4_dense_engine #(.RELU(1)) dut_relu (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus1)
  );

  logic signed [31:0] rom  [0:319];
  logic signed [31:0] acts [0:31];

  assign bus0.weight_data = (bus0.weight_addr < 16'd320) ? rom[bus0.weight_addr[8:0]] : 32'sd0;
  assign bus1.weight_data = (bus1.weight_addr < 16'd320) ? rom[bus1.weight_addr[8:0]] : 32'sd0;
  assign bus0.act_data    = acts[bus0.act_addr];
  assign bus1.act_data    = acts[bus1.act_addr];

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   checks = 0;
  int   passes = 0;

  // Scoreboard: every write strobe pops the next expected write.
  always @(negedge clk) begin
    if (bus0.out_we === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        $display("[TB] FAIL sb0 write: got unexpected addr=%0d data=%h, required no write",
                 bus0.out_addr, bus0.out_data);
      end else begin
        e0 = q0.pop_front();
        if (bus0.out_addr !== e0.addr || bus0.out_data !== e0.data)
          $display("[TB] FAIL sb0 write: got addr=%0d data=%h, required addr=%0d data=%h",
                   bus0.out_addr, bus0.out_data, e0.addr, e0.data);
        else passes++;
      end
    end
    if (bus1.out_we === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        $display("[TB] FAIL sb1 write: got unexpected addr=%0d data=%h, required no write",
                 bus1.out_addr, bus1.out_data);
      end else begin
        e1 = q1.pop_front();
        if (bus1.out_addr !== e1.addr || bus1.out_data !== e1.data)
          $display("[TB] FAIL sb1 write: got addr=%0d data=%h, required addr=%0d data=%h",
                   bus1.out_addr, bus1.out_data, e1.addr, e1.data);
        else passes++;
      end
    end
  end

  task automatic fill_rom(input logic [31:0] v);
    for (int a = 0; a < 320; a++) rom[a] = v;
  endtask

  task automatic set_row(input int o, input logic [31:0] v);
    for (int i = 0; i < 32; i++) rom[o*32 + i] = v;
  endtask

  task automatic set_acts(input logic [31:0] v);
    for (int a = 0; a < 32; a++) acts[a] = v;
  endtask

  // The RELU=1 instance expects negatives replaced by zero.
  task automatic push_row(input int o, input logic [31:0] v);
    exp_t t;
    t.addr = 4'(o);
    t.data = v;
    q0.push_back(t);
    t.data = v[31] ? 32'h0 : v;
    q1.push_back(t);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus0.start = 1'b1;
    bus1.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask

  // Returns the cycle (counted from the accept edge) at which done is seen,
  // or -1 if it never arrives within the budget. Leaves time at that negedge.
  task automatic run_to_done(output int lat);
    lat = -1;
    pulse_start();
    for (int k = 1; k <= 400; k++) begin
      if (k > 1) @(negedge clk);
      if (bus0.done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus0.busy !== 1'b0) $display("[TB] FAIL reset busy: got %b, required 0", bus0.busy); else passes++;
    checks++; if (bus0.done !== 1'b0) $display("[TB] FAIL reset done: got %b, required 0", bus0.done); else passes++;
    checks++; if (bus0.out_we !== 1'b0) $display("[TB] FAIL reset out_we: got %b, required 0", bus0.out_we); else passes++;
    checks++; if (bus0.weight_addr !== 16'h0) $display("[TB] FAIL reset weight_addr: got %h, required 0", bus0.weight_addr); else passes++;
    checks++; if (bus0.act_addr !== 5'h0) $display("[TB] FAIL reset act_addr: got %h, required 0", bus0.act_addr); else passes++;
    checks++; if (bus0.out_addr !== 4'h0) $display("[TB] FAIL reset out_addr: got %h, required 0", bus0.out_addr); else passes++;
    checks++; if (bus0.out_data !== 32'h0) $display("[TB] FAIL reset out_data: got %h, required 0", bus0.out_data); else passes++;
    checks++; if (bus0.argmax !== 4'h0) $display("[TB] FAIL reset argmax: got %h, required 0", bus0.argmax); else passes++;
    checks++; if (bus1.busy !== 1'b0) $display("[TB] FAIL reset busy relu: got %b, required 0", bus1.busy); else passes++;
    resetn = 1'b1;
  endtask

  task automatic test_timing_ones();
    logic        exp_we, exp_busy, exp_done;
    logic [15:0] exp_wa;
    logic [4:0]  exp_aa;
    fill_rom(32'h0001_0000);
    set_acts(32'h0001_0000);
    for (int o = 0; o < 10; o++) push_row(o, 32'h0020_0000);
    pulse_start();
    for (int k = 1; k <= 335; k++) begin
      if (k > 1) @(negedge clk);
      exp_we   = (k % 33 == 0) && (k <= 330);
      exp_busy = (k <= 330);
      exp_done = (k == 331);
      checks++; if (bus0.out_we !== exp_we) $display("[TB] FAIL timing out_we cycle %0d: got %b, required %b", k, bus0.out_we, exp_we); else passes++;
      checks++; if (bus0.busy !== exp_busy) $display("[TB] FAIL timing busy cycle %0d: got %b, required %b", k, bus0.busy, exp_busy); else passes++;
      checks++; if (bus0.done !== exp_done) $display("[TB] FAIL timing done cycle %0d: got %b, required %b", k, bus0.done, exp_done); else passes++;
      if (k == 1 || k == 17 || k == 32 || k == 34 || k == 65) begin
        exp_wa = (k < 33) ? 16'(k - 1) : 16'(32 + k - 34);
        exp_aa = (k < 33) ? 5'(k - 1) : 5'(k - 34);
        checks++; if (bus0.weight_addr !== exp_wa) $display("[TB] FAIL timing weight_addr cycle %0d: got %0d, required %0d", k, bus0.weight_addr, exp_wa); else passes++;
        checks++; if (bus0.act_addr !== exp_aa) $display("[TB] FAIL timing act_addr cycle %0d: got %0d, required %0d", k, bus0.act_addr, exp_aa); else passes++;
      end
      if (k == 331) begin
        checks++; if (bus0.argmax !== 4'd0) $display("[TB] FAIL ones argmax: got %0d, required 0", bus0.argmax); else passes++;
      end
    end
    checks++; if (q0.size() != 0 || q1.size() != 0) $display("[TB] FAIL ones pending writes: got %0d/%0d, required 0/0", q0.size(), q1.size()); else passes++;
  endtask

  task automatic test_saturation();
    int lat;
    fill_rom(32'h7FFF_FFFF);
    set_acts(32'h7FFF_FFFF);
    for (int o = 0; o < 10; o++) push_row(o, 32'h7FFF_FFFF);
    run_to_done(lat);
    checks++; if (lat != 331) $display("[TB] FAIL sat_pos latency: got %0d, required 331", lat); else passes++;
    checks++; if (q0.size() != 0 || q1.size() != 0) $display("[TB] FAIL sat_pos pending writes: got %0d/%0d, required 0/0", q0.size(), q1.size()); else passes++;
    fill_rom(32'h8000_0000);
    for (int o = 0; o < 10; o++) push_row(o, 32'h8000_0000);
    run_to_done(lat);
    checks++; if (lat != 331) $display("[TB] FAIL sat_neg latency: got %0d, required 331", lat); else passes++;
    checks++; if (q0.size() != 0 || q1.size() != 0) $display("[TB] FAIL sat_neg pending writes: got %0d/%0d, required 0/0", q0.size(), q1.size()); else passes++;
    checks++; if (bus0.argmax !== 4'd0) $display("[TB] FAIL sat_neg argmax: got %0d, required 0", bus0.argmax); else passes++;
  endtask

  task automatic test_relu();
    int lat;
    fill_rom(32'hFFFF_0000);
    set_acts(32'h0001_0000);
    for (int o = 0; o < 10; o++) push_row(o, 32'hFFE0_0000);
    run_to_done(lat);
    checks++; if (lat != 331) $display("[TB] FAIL relu latency: got %0d, required 331", lat); else passes++;
    checks++; if (q0.size() != 0 || q1.size() != 0) $display("[TB] FAIL relu pending writes: got %0d/%0d, required 0/0", q0.size(), q1.size()); else passes++;
    checks++; if (bus1.done !== 1'b1) $display("[TB] FAIL relu done relu-instance: got %b, required 1", bus1.done); else passes++;
    checks++; if (bus1.argmax !== 4'd0) $display("[TB] FAIL relu argmax: got %0d, required 0", bus1.argmax); else passes++;
  endtask

  task automatic test_argmax();
    int lat;
    fill_rom(32'h0001_0000);
    set_row(3, 32'h0002_0000);
    set_row(7, 32'h0002_0000);
    set_acts(32'h0001_0000);
    for (int o = 0; o < 10; o++) push_row(o, (o == 3 || o == 7) ? 32'h0040_0000 : 32'h0020_0000);
    run_to_done(lat);
    checks++; if (lat != 331) $display("[TB] FAIL argmax_tie latency: got %0d, required 331", lat); else passes++;
    checks++; if (bus0.argmax !== 4'd3) $display("[TB] FAIL argmax_tie: got %0d, required 3", bus0.argmax); else passes++;
    checks++; if (bus1.argmax !== 4'd3) $display("[TB] FAIL argmax_tie relu: got %0d, required 3", bus1.argmax); else passes++;
    set_row(7, 32'h0003_0000);
    for (int o = 0; o < 10; o++)
      push_row(o, (o == 7) ? 32'h0060_0000 : ((o == 3) ? 32'h0040_0000 : 32'h0020_0000));
    run_to_done(lat);
    checks++; if (lat != 331) $display("[TB] FAIL argmax_row7 latency: got %0d, required 331", lat); else passes++;
    checks++; if (bus0.argmax !== 4'd7) $display("[TB] FAIL argmax_row7: got %0d, required 7", bus0.argmax); else passes++;
    repeat (5) @(negedge clk);
    checks++; if (bus0.argmax !== 4'd7) $display("[TB] FAIL argmax_hold: got %0d, required 7", bus0.argmax); else passes++;
    checks++; if (q0.size() != 0 || q1.size() != 0) $display("[TB] FAIL argmax pending writes: got %0d/%0d, required 0/0", q0.size(), q1.size()); else passes++;
  endtask

  task automatic test_abort_restart();
    int lat;
    int busy_cnt, done_cnt, we_cnt;
    fill_rom(32'h0001_0000);
    set_acts(32'h0001_0000);
    for (int o = 0; o < 10; o++) push_row(o, 32'h0020_0000);
    pulse_start();
    for (int k = 2; k <= 100; k++) @(negedge clk);
    resetn = 1'b0;
    checks++; if (q0.size() != 7) $display("[TB] FAIL abort writes before reset: got %0d pending, required 7", q0.size()); else passes++;
    q0.delete();
    q1.delete();
    @(negedge clk);
    checks++; if (bus0.busy !== 1'b0) $display("[TB] FAIL abort busy: got %b, required 0", bus0.busy); else passes++;
    checks++; if (bus0.out_data !== 32'h0) $display("[TB] FAIL abort out_data: got %h, required 0", bus0.out_data); else passes++;
    checks++; if (bus0.weight_addr !== 16'h0) $display("[TB] FAIL abort weight_addr: got %h, required 0", bus0.weight_addr); else passes++;
    checks++; if (bus0.act_addr !== 5'h0) $display("[TB] FAIL abort act_addr: got %h, required 0", bus0.act_addr); else passes++;
    checks++; if (bus0.out_addr !== 4'h0) $display("[TB] FAIL abort out_addr: got %h, required 0", bus0.out_addr); else passes++;
    resetn = 1'b1;
    busy_cnt = 0; done_cnt = 0; we_cnt = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus0.busy !== 1'b0 || bus1.busy !== 1'b0) busy_cnt++;
      if (bus0.done !== 1'b0 || bus1.done !== 1'b0) done_cnt++;
      if (bus0.out_we !== 1'b0 || bus1.out_we !== 1'b0) we_cnt++;
    end
    checks++; if (busy_cnt != 0) $display("[TB] FAIL abort idle busy: got %0d cycles, required 0", busy_cnt); else passes++;
    checks++; if (done_cnt != 0) $display("[TB] FAIL abort idle done: got %0d cycles, required 0", done_cnt); else passes++;
    checks++; if (we_cnt != 0) $display("[TB] FAIL abort idle out_we: got %0d cycles, required 0", we_cnt); else passes++;
    // Restart with a stray start while busy.
    for (int o = 0; o < 10; o++) push_row(o, 32'h0020_0000);
    pulse_start();
    lat = -1;
    for (int k = 1; k <= 400; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 50) begin
        bus0.start = 1'b1;
        bus1.start = 1'b1;
      end else if (k == 51) begin
        bus0.start = 1'b0;
        bus1.start = 1'b0;
      end
      if (bus0.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++; if (lat != 331) $display("[TB] FAIL restart latency: got %0d, required 331", lat); else passes++;
    checks++; if (q0.size() != 0 || q1.size() != 0) $display("[TB] FAIL restart pending writes: got %0d/%0d, required 0/0", q0.size(), q1.size()); else passes++;
  endtask

  task automatic test_back_to_back();
    int lat, lat2;
    fill_rom(32'h0001_0000);
    set_row(5, 32'h0002_0000);
    set_acts(32'h0001_0000);
    for (int r = 0; r < 2; r++)
      for (int o = 0; o < 10; o++) push_row(o, (o == 5) ? 32'h0040_0000 : 32'h0020_0000);
    run_to_done(lat);
    checks++; if (lat != 331) $display("[TB] FAIL b2b first latency: got %0d, required 331", lat); else passes++;
    bus0.start = 1'b1;
    bus1.start = 1'b1;
    @(negedge clk);
    checks++; if (bus0.busy !== 1'b0) $display("[TB] FAIL b2b start in done cycle: got busy %b, required 0", bus0.busy); else passes++;
    @(negedge clk);
    checks++; if (bus0.busy !== 1'b1) $display("[TB] FAIL b2b start in idle: got busy %b, required 1", bus0.busy); else passes++;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    lat2 = -1;
    for (int k = 1; k <= 400; k++) begin
      if (k > 1) @(negedge clk);
      if (bus0.done === 1'b1) begin
        lat2 = k;
        break;
      end
    end
    checks++; if (lat2 != 331) $display("[TB] FAIL b2b second latency: got %0d, required 331", lat2); else passes++;
    checks++; if (bus0.argmax !== 4'd5) $display("[TB] FAIL b2b argmax: got %0d, required 5", bus0.argmax); else passes++;
    checks++; if (q0.size() != 0 || q1.size() != 0) $display("[TB] FAIL b2b pending writes: got %0d/%0d, required 0/0", q0.size(), q1.size()); else passes++;
  endtask

  initial begin
    resetn     = 1'b0;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    fill_rom(32'h0);
    set_acts(32'h0);
    $display("[TB] starting layer4_dense_engine tests");
    test_reset();
    test_timing_ones();
    test_saturation();
    test_relu();
    test_argmax();
    test_abort_restart();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/layer4_dense_engine.md
Name: layer4_dense_engine

Overview:
- Sequential consumer of the layer-4 weight ROM: 320 × 32-bit signed words, 16-bit address, combinational read.
- Computes a 10-output × 32-input fully-connected layer in Q16.16 fixed point.
- Reads activations from the layer-3 output buffer and writes 10 results to the layer-4 result buffer.
- Reports the argmax class index as the network's predicted digit.

Parameters:
- IN_DIM, 32, inputs per neuron (activation count).
- OUT_DIM, 10, output neurons.
- FRAC_BITS, 16, fractional bits of weights, activations and results.
- W_BASE, 0, base weight-ROM address of row 0.
- RELU, 0, 1 = clamp negative results to 0 before writeback.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  synchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- busy  out  1  high from the cycle after start accept until done.
- done  out  1  one-cycle pulse when all outputs are written.
- weight_addr  out  16  to weight ROM; registered.
- weight_data  in  32  signed ROM data, valid same cycle as weight_addr.
- act_addr  out  5  to activation buffer; registered.
- act_data  in  32  signed activation, valid same cycle as act_addr.
- out_we  out  1  result write strobe.
- out_addr  out  4  result index 0..OUT_DIM-1.
- out_data  out  32  signed Q16.16 result.
- argmax  out  4  index of the largest result; valid when done=1, held until next start accept.

Behaviour:
- Reset: applies when resetn=0 on a clk edge.
  - State goes to IDLE.
  - busy, done, out_we = 0; weight_addr, act_addr, out_addr, out_data, argmax = 0.
  - Accumulator and counters cleared.
  - Reset mid-operation aborts with no further writes.
- Weight layout: row-major by neuron, weight_addr = W_BASE + o*IN_DIM + i.
- FSM states: IDLE, MAC, WRITE, DONE.
  - IDLE: on start=1 → MAC. Set o=0, i=0, acc=0, max=most-negative, argmax=0. start in any other state is ignored.
  - MAC: one input per cycle.
    - acc += weight_data*act_data (64-bit product, 72-bit signed accumulator, no intermediate truncation).
    - i increments; when i=IN_DIM-1 → WRITE.
    - Addresses are registered so ROM/buffer outputs are stable during the cycle.
  - WRITE: result = acc >>> FRAC_BITS (arithmetic), saturated to [0x80000000, 0x7FFFFFFF], then ReLU if RELU=1.
    - out_we=1 for exactly this cycle with out_addr=o and out_data=result.
    - If result > max (strict): update max and argmax=o. Ties keep the lower index.
    - Clear acc and i. If o=OUT_DIM-1 → DONE, else o++ and → MAC.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Timing with start accepted at edge 0:
  - Neuron o writes at cycle 33*(o+1).
  - Last write at cycle 330; done at cycle 331.
  - Per run: OUT_DIM*(IN_DIM+1)+1 cycles.
- out_data holds its last written value between writes; out_we is low outside WRITE.
- Back-to-back: start in the done cycle is ignored; start in the following IDLE cycle is accepted.

Decomposition:
- Shared package nn_pkg:
  - FRAC_BITS, L4_IN_DIM, L4_OUT_DIM, L4_W_BASE.
  - Fixed-point saturation limits.
  - State encoding typedef for the dense-engine FSM (shared with other layer engines).
- One sub-module, fx_requant (combinational): 72-bit accumulator → arithmetic shift → saturate → optional ReLU → 32-bit.
  - Reused by the other layer engines.

Test Plan:
- All weights 0x00010000, all activations 0x00010000 → every out_data = 0x00200000 (32.0); argmax=0 (tie → lowest index).
- Timing: start at cycle 0 → out_we at cycles 33, 66, …, 330 with out_addr 0..9; done only at cycle 331; busy high for cycles 1..330.
- Weights 0x7FFFFFFF, activations 0x7FFFFFFF → out_data 0x7FFFFFFF. Weights 0x80000000 with activations 0x7FFFFFFF → 0x80000000.
- Weights −1.0 (0xFFFF0000), activations 1.0:
  - RELU=0 → 0xFFE00000.
  - RELU=1 → 0x00000000.
- Argmax: rows 3 and 7 weights 2.0, others 1.0, activations 1.0 → results 0x00400000 at indices 3 and 7; argmax=3. Then make row 7 = 3.0 → argmax=7.
- Abort and restart:
  - resetn=0 at cycle 100 → no out_we after reset, done never pulses, busy=0.
  - A new start then completes a full 331-cycle run with correct results.
  - A start pulse while busy has no effect on timing or results.
